fetch_queue: RTL
================

# fetch_queue

Parametrised instruction prefetch buffer between the combined instruction/data memory and the IF/ID register of the pipelined CPU. It runs ahead of decode, keeping up to DEPTH fetched instructions, each paired with its PC+4. It discards wrong-path words when a branch or jump redirect arrives, and stops fetching after the halt word 32'hfc000000. It replaces the direct `pc`/`pc + 4` fetch path and decouples decode from variable memory latency.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 32, address/PC width
- RESET_PC, 0, fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- pc_rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request
- imem_addr  output  ADDR_W  fetch address, word aligned
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid (in order, ≥1 cycle after gnt)
- imem_rdata  input  32  fetched instruction
- redirect  input  1  flush and refetch (branch/jump taken in decode)
- redirect_pc  input  ADDR_W  new fetch address
- deq_ready  input  1  IF/ID enable (consumer accepts head)
- deq_valid  output  1  head entry valid
- deq_instr  output  32  head instruction
- deq_pcp4  output  ADDR_W  head PC+4
- count  output  $clog2(DEPTH+1)  entries held
- halted  output  1  halt word delivered

## Operation
- State: circular storage {instr, pcp4} × DEPTH, rd/wr pointers, count, fetch PC `fpc`, `outstanding` flag (max one in flight), `drop` flag, `stop` flag, `halted`.
- imem_req = pc_rst_n & !stop & !outstanding & (count < DEPTH); imem_addr = fpc.
- Credit rule: a request is issued only if count + outstanding < DEPTH. The queue therefore never overflows, and imem_rvalid is always accepted.
- On req&gnt: outstanding←1, fpc←fpc+4 (mod 2^ADDR_W, wraps silently), pcp4 of the in-flight word = granted address + 4.
- On rvalid: outstanding←0. If drop=1, the word is discarded and drop←0. Otherwise the word is pushed. If the word is 32'hfc000000, stop←1 and no further requests are issued.
- Dequeue when deq_valid & deq_ready. If the dequeued word is 32'hfc000000, halted←1 (sticky until reset).
- Redirect (highest priority):
  - queue emptied (count←0, pointers reset)
  - fpc←redirect_pc
  - stop←0
  - drop←outstanding & !rvalid
  - a same-cycle rvalid word is discarded, and a same-cycle dequeue still completes
  - a same-cycle grant is treated as in flight (drop←1, fpc←redirect_pc, not redirect_pc+4)
- Simultaneous push and pop: count unchanged, both pointers advance. Pop on empty and push when full cannot occur.
- Reset mid-fetch: all state cleared immediately. A later rvalid from the abandoned request is ignored (outstanding=0).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, deq_valid 0, deq_instr 0, deq_pcp4 0, count 0, halted 0.
- Outputs deq_* and count are driven from registers and storage only, with no combinational path from imem_* or deq_ready (except under bypass, see Configuration).
- Miss-to-decode latency: gnt in cycle n, rvalid in cycle n+k, deq_valid high in cycle n+k+1.
- Steady throughput with single-cycle memory (rvalid the cycle after gnt): one instruction per 2 cycles. imem_req reasserts the cycle after rvalid.
- imem_addr is held stable while imem_req=1 and gnt=0, unless redirect changes it on the next edge.
- Redirect at cycle n: deq_valid=0 at n+1, imem_req=1 with imem_addr=redirect_pc at n+1 (if not dropping).

## Configuration
- FETCHQ_BYPASS_EN defined:
  - when the queue is empty, rvalid=1, drop=0, no redirect and deq_ready=1, the word is presented on deq_valid/deq_instr/deq_pcp4 in the same cycle and not stored
  - miss-to-decode latency drops to n+k
  - halt detection still applies
- FETCHQ_BYPASS_EN undefined: no combinational path from imem_rdata to deq_*. Latency is as in Timing.

## Test plan
- Reset with pc_rst_n=0 for 3 cycles, RESET_PC=0 -> all outputs at reset values. First cycle after release: imem_req=1, imem_addr=0.
- Memory granting every request, rvalid 1 cycle later, deq_ready=0, DEPTH=4 -> exactly 4 grants (addresses 0,4,8,12), count=4, imem_req=0. Then deq_ready=1 -> words dequeued in order with deq_pcp4 = 4, 8, 12, 16.
- Redirect to 0x100 while a fetch of 0x8 is outstanding, rvalid 2 cycles later -> the 0x8 word is discarded, count=0, next imem_addr=0x100, and the first dequeued deq_pcp4 is 0x104.
- Redirect in the same cycle as rvalid and a dequeue -> dequeue completes, rvalid word dropped, count=0 next cycle, drop=0.
- Memory returns 32'hfc000000 at address 0x10 -> no request to 0x14, halt word dequeued, halted=1 the next cycle and stays 1 through further deq_ready cycles.
- With FETCHQ_BYPASS_EN, empty queue, rvalid with 0x2002000a and deq_ready=1 -> deq_valid=1, deq_instr=0x2002000a in the same cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between the unified memory and IF/ID, with PC-redirect flush and halt stop.
// Optional FETCHQ_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       pc_rst_n,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [ADDR_W-1:0]          deq_pcp4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH+1);
  localparam logic [31:0] HaltWord = 32'hfc000000;

  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pcp4_q  [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [ADDR_W-1:0] fpc_q, inflight_pcp4_q;
  logic              outstanding_q, drop_q, stop_q, halted_q;

  logic gnt_fire, rv, rv_keep, bypass, push, pop, deq_fire;

  // Requests only when nothing is in flight, so a free slot is always reserved for the reply.
  assign imem_req  = pc_rst_n & ~stop_q & ~outstanding_q & (count_q < CntW'(DEPTH));
  assign imem_addr = fpc_q;

  assign gnt_fire = imem_req & imem_gnt;
  assign rv       = imem_rvalid & outstanding_q;
  assign rv_keep  = rv & ~drop_q & ~redirect;

`ifdef FETCHQ_BYPASS_EN
  assign bypass    = rv_keep & (count_q == '0) & deq_ready;
  assign deq_valid = (count_q != '0) | bypass;
  assign deq_instr = bypass ? imem_rdata : instr_q[rd_ptr_q];
  assign deq_pcp4  = bypass ? inflight_pcp4_q : pcp4_q[rd_ptr_q];
`else
  assign bypass    = 1'b0;
  assign deq_valid = (count_q != '0);
  assign deq_instr = instr_q[rd_ptr_q];
  assign deq_pcp4  = pcp4_q[rd_ptr_q];
`endif

  assign push     = rv_keep & ~bypass;
  assign pop      = (count_q != '0) & deq_ready;
  assign deq_fire = deq_valid & deq_ready;

  assign count  = count_q;
  assign halted = halted_q;

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pcp4_q[i]  <= '0;
      end
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      fpc_q           <= RESET_PC;
      inflight_pcp4_q <= '0;
      outstanding_q   <= 1'b0;
      drop_q          <= 1'b0;
      stop_q          <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      if (deq_fire && deq_instr == HaltWord) begin
        halted_q <= 1'b1;
      end
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        fpc_q    <= redirect_pc;
        stop_q   <= 1'b0;
        // A request granted this cycle still returns a wrong-path word that must be skipped.
        drop_q        <= gnt_fire | (outstanding_q & ~imem_rvalid);
        outstanding_q <= gnt_fire | (outstanding_q & ~imem_rvalid);
      end else begin
        if (gnt_fire) begin
          outstanding_q   <= 1'b1;
          fpc_q           <= fpc_q + ADDR_W'(4);
          inflight_pcp4_q <= fpc_q + ADDR_W'(4);
        end else if (rv) begin
          outstanding_q <= 1'b0;
        end
        if (rv && drop_q) begin
          drop_q <= 1'b0;
        end
        if (rv_keep && imem_rdata == HaltWord) begin
          stop_q <= 1'b1;
        end
        if (push) begin
          instr_q[wr_ptr_q] <= imem_rdata;
          pcp4_q[wr_ptr_q]  <= inflight_pcp4_q;
          wr_ptr_q          <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

endmodule
